// File: rtl/rob_pr_free_q.sv
// Commit-group queue between ROB commit and the banked free_list: buffers freed PRs and
// routes the oldest group's PRs to their banks, one PR per bank per cycle, lowest way first.
module rob_pr_free_q #(
  parameter int ENTRIES = 2,
  parameter int WAYS    = 4,
  parameter int BANKS   = 4,
  parameter int PR_W    = 7
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       enq_valid,
  input  logic [WAYS-1:0]            enq_valid_by_way,
  input  logic [WAYS-1:0][PR_W-1:0]  enq_PR_by_way,
  output logic                       enq_ready,
  output logic [BANKS-1:0]           free_valid_by_bank,
  output logic [BANKS-1:0][PR_W-1:0] free_PR_by_bank,
  input  logic [BANKS-1:0]           free_ready_by_bank
);

  localparam int BANK_BITS = $clog2(BANKS);
  localparam int PTR_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W     = $clog2(ENTRIES + 1);
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_reg [ENTRIES];
  logic [PR_W-1:0]  pr_reg    [ENTRIES][WAYS];
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [WAYS-1:0]  head_valid;
  logic [PR_W-1:0]  head_pr [WAYS];
  logic [WAY_W-1:0] sel_way [BANKS];
  logic [WAYS-1:0]  deliver;
  logic [WAYS-1:0]  remain;
  logic             enq_fire;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // enq_ready depends on registered count only, never on free-side ready.
  assign enq_ready  = (count_reg != CNT_W'(ENTRIES));
  assign enq_fire   = enq_valid && enq_ready && (|enq_valid_by_way);
  assign head_valid = valid_reg[head_reg];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_head
    assign head_pr[gi] = pr_reg[head_reg][gi];
  end

  // Per bank: lowest valid way of the head entry whose PR maps to this bank.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic             found;
    logic [WAY_W-1:0] way;
    always_comb begin
      found = 1'b0;
      way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (head_valid[w] && head_pr[w][BANK_BITS-1:0] == BANK_BITS'(gi)) begin
          found = 1'b1;
          way   = WAY_W'(w);
        end
      end
    end
    assign sel_way[gi]            = way;
    assign free_valid_by_bank[gi] = found;
    assign free_PR_by_bank[gi]    = found ? head_pr[way] : '0;
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [BANK_BITS-1:0] bank;
    assign bank        = head_pr[gi][BANK_BITS-1:0];
    assign deliver[gi] = head_valid[gi] && free_ready_by_bank[bank] &&
                         (sel_way[bank] == WAY_W'(gi));
  end

  assign remain = head_valid & ~deliver;
  assign pop    = (count_reg != '0) && (remain == '0);

  always_comb begin
    head_next  = pop ? ptr_inc(head_reg) : head_reg;
    tail_next  = enq_fire ? ptr_inc(tail_reg) : tail_reg;
    count_next = count_reg;
    if (enq_fire && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !enq_fire) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        valid_reg[e] <= '0;
      end
    end else begin
      if (count_reg != '0) begin
        valid_reg[head_reg] <= remain;
      end
      // Tail never aliases a non-empty head here: full blocks enqueue.
      if (enq_fire) begin
        valid_reg[tail_reg] <= enq_valid_by_way;
      end
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      for (int w = 0; w < WAYS; w++) begin
        pr_reg[tail_reg][w] <= enq_PR_by_way[w];
      end
    end
  end

endmodule
